// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register bank.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one async pin with rise/fall pulses.
// primed_o goes high once the chain has been flushed with real pin samples
// after reset, so that edges created by the reset level are not trusted.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o,
  output logic primed_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic [STAGES:0]   prime_q;
  logic [STAGES:0]   prime_d;

  // next-state for the synchronizer chain and the flush tracker
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d_i};
    prime_d = {prime_q[STAGES-1:0], 1'b1};
  end

  // synchronizer, previous-sample and flush flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
      prime_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= sync_q[STAGES-1];
      prime_q <= prime_d;
    end
  end

  assign lvl_o    = sync_q[STAGES-1];
  assign rise_o   =  sync_q[STAGES-1] & ~prev_q;
  assign fall_o   = ~sync_q[STAGES-1] &  prev_q;
  assign primed_o = prime_q[STAGES];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank feeding the PWM peripheral.
// Frames: [15]=R/W (1=write), [14:8]=addr, [7:0]=data, MSB first.
// Optional readback of registers over cipo_o is enabled by defining
// SPI_READBACK_EN; without it cipo_o is 0 and read frames are dropped.
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       copi_i,
  input  logic       ncs_i,
  output logic       cipo_o,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done
);

  import spi_reg_pkg::*;

  localparam int               CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(FRAME_BITS + 1);
  localparam logic [6:0]       NUM_REGS_A = 7'(NUM_REGS);

  // ---- pin synchronization ----
  logic sclk_lvl, sclk_rise, sclk_fall, sclk_primed;
  logic ncs_lvl,  ncs_rise,  ncs_fall,  ncs_primed;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk_i),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall), .primed_o(sclk_primed)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs_i),
    .lvl_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall), .primed_o(ncs_primed)
  );

  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_d;
  logic                   copi_s;

  // copi only needs a plain synchronizer; it is sampled on sclk edges
  always_comb copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi_i};

  // copi synchronizer flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) copi_sync_q <= '0;
    else        copi_sync_q <= copi_sync_d;
  end

  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  // ---- frame state ----
  state_e                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [FRAME_BITS-1:0]   shift_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    armed_q;
  logic                    frame_done_q;
  logic [7:0]              out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;

  logic                    rw_bit;
  logic [6:0]              addr_f;
  logic [7:0]              data_f;
  logic                    full_frame;
  logic                    wr_ok;

  // next shift value / saturating bit count for an accepted sclk rise
  always_comb begin
    shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // field decode of the captured frame, used in COMMIT
  always_comb begin
    rw_bit     = shift_q[FRAME_BITS-1];
    addr_f     = shift_q[FRAME_BITS-2 -: 7];
    data_f     = shift_q[7:0];
    full_frame = (cnt_q == CNT_FULL);
    wr_ok      = full_frame && rw_bit && (addr_f < NUM_REGS_A);
  end

`ifdef SPI_READBACK_EN
  logic [7:0] out_sh_q;
  logic       cipo_q;
  logic [7:0] rd_data;
  logic       rd_ok;

  // register selected by the address byte that the current sclk rise completes
  always_comb begin
    rd_data = 8'h00;
    if (!shift_d[7]) begin
      case (shift_d[6:0])
        ADDR_EN_OUT_LO: rd_data = out_lo_q;
        ADDR_EN_OUT_HI: rd_data = out_hi_q;
        ADDR_EN_PWM_LO: rd_data = pwm_lo_q;
        ADDR_EN_PWM_HI: rd_data = pwm_hi_q;
        ADDR_DUTY:      rd_data = duty_q;
        default:        rd_data = 8'h00;
      endcase
    end
    rd_ok = full_frame && !rw_bit && (addr_f < NUM_REGS_A);
  end

  // readback shifter: loaded on the 8th sclk rise, MSB out on each sclk fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sh_q <= '0;
      cipo_q   <= 1'b0;
    end else if (state_q != SHIFT || ncs_lvl) begin
      out_sh_q <= '0;
      cipo_q   <= 1'b0;
    end else if (sclk_rise && cnt_q == CNT_W'(7)) begin
      out_sh_q <= rd_data;
    end else if (sclk_fall && cnt_q >= CNT_W'(8)) begin
      cipo_q   <= out_sh_q[7];
      out_sh_q <= {out_sh_q[6:0], 1'b0};
    end
  end

  assign cipo_o = cipo_q;
`else
  assign cipo_o = 1'b0;
`endif

  // frame FSM with registered register-bank and frame_done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      frame_done_q <= 1'b0;
      out_lo_q     <= 8'h00;
      out_hi_q     <= 8'h00;
      pwm_lo_q     <= 8'h00;
      pwm_hi_q     <= 8'h00;
      duty_q       <= 8'h00;
    end else begin
      frame_done_q <= 1'b0;
      // only a genuine high-to-low ncs after reset may open a frame
      if (ncs_primed && sclk_primed && ncs_lvl) armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (ncs_fall && armed_q) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          // ncs rise wins over a coincident sclk rise
          if (ncs_rise) begin
            state_q <= COMMIT;
          end else if (sclk_rise) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (wr_ok) begin
            frame_done_q <= 1'b1;
            case (addr_f)
              ADDR_EN_OUT_LO: out_lo_q <= data_f;
              ADDR_EN_OUT_HI: out_hi_q <= data_f;
              ADDR_EN_PWM_LO: pwm_lo_q <= data_f;
              ADDR_EN_PWM_HI: pwm_hi_q <= data_f;
              ADDR_DUTY:      duty_q   <= data_f;
              default: ;
            endcase
          end
`ifdef SPI_READBACK_EN
          if (rd_ok) frame_done_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed, table-driven bench for spi_reg_bank.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_i, copi_i, ncs_i;
  logic       cipo_o;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       frame_done;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk_i(sclk_i), .copi_i(copi_i), .ncs_i(ncs_i),
    .cipo_o(cipo_o),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // frame_done pulses, sampled away from the active edge
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

`ifdef SPI_READBACK_EN
  localparam int RD_DONE = 1;
`else
  localparam int RD_DONE = 0;
`endif

  typedef struct {
    string       name;
    logic [31:0] frame;
    int          nbits;
    logic [39:0] regs;   // {out_lo, out_hi, pwm_lo, pwm_hi, duty}
    int          done;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string n, logic [31:0] f, int b, logic [39:0] r, int d);
    vec_t v;
    v.name = n; v.frame = f; v.nbits = b; v.regs = r; v.done = d;
    return v;
  endfunction

  function automatic logic [39:0] regs_now();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // clock out n bits MSB first with ncs already low; returns cipo sampled on rises 9..16
  task automatic spi_bits(input logic [31:0] bits, input int n, input int first_k, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      int k;
      k = first_k + (n - 1 - i);
      copi_i = bits[i];
      #40;
      if (k >= 8 && k < 16) rd = {rd[6:0], cipo_o};
      sclk_i = 1'b1;
      #40;
      sclk_i = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int n, output logic [7:0] rd);
    ncs_i = 1'b0;
    #40;
    spi_bits(bits, n, 0, rd);
    #40;
    ncs_i = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0] rd;
    int         d0;

    vecs[0]  = mk("wr_pwm_lo",   32'h8255,  16, 40'h00_00_55_00_00, 1);
    vecs[1]  = mk("wr_duty_ff",  32'h84FF,  16, 40'h00_00_55_00_FF, 1);
    vecs[2]  = mk("wr_addr5",    32'h85AA,  16, 40'h00_00_55_00_FF, 0);
    vecs[3]  = mk("short15",     32'h4078,  15, 40'h00_00_55_00_FF, 0);
    vecs[4]  = mk("long17",      32'h101E0, 17, 40'h00_00_55_00_FF, 0);
    vecs[5]  = mk("wr_out_hi",   32'h8103,  16, 40'h00_03_55_00_FF, 1);
    vecs[6]  = mk("wr_pwm_hi",   32'h837F,  16, 40'h00_03_55_7F_FF, 1);
    vecs[7]  = mk("read_a1",     32'h0155,  16, 40'h00_03_55_7F_FF, RD_DONE);
    vecs[8]  = mk("overwrite",   32'h8211,  16, 40'h00_03_11_7F_FF, 1);
    vecs[9]  = mk("wr_addr7f",   32'hFF12,  16, 40'h00_03_11_7F_FF, 0);
    vecs[10] = mk("wr_addr4",    32'h8480,  16, 40'h00_03_11_7F_80, 1);

    rst_n = 1'b0; sclk_i = 1'b0; copi_i = 1'b0; ncs_i = 1'b1;
    #52;
    check("reset_regs", 64'(regs_now()), 64'h0);
    check("reset_done", 64'(frame_done), 64'h0);
    check("reset_cipo", 64'(cipo_o), 64'h0);
    rst_n = 1'b1;
    #100;

    foreach (vecs[i]) begin
      d0 = done_cnt;
      spi_frame(vecs[i].frame, vecs[i].nbits, rd);
      check({vecs[i].name, "_regs"}, 64'(regs_now()), 64'(vecs[i].regs));
      check({vecs[i].name, "_done"}, 64'(done_cnt - d0), 64'(vecs[i].done));
    end

    // reset mid-run clears everything, no frame_done
    d0 = done_cnt;
    #3 rst_n = 1'b0;
    #100;
    check("midrun_rst_regs", 64'(regs_now()), 64'h0);
    rst_n = 1'b1;
    #100;
    check("midrun_rst_done", 64'(done_cnt - d0), 64'h0);

    // reset after 8 bits, released with ncs still low, frame then completed
    d0 = done_cnt;
    ncs_i = 1'b0;
    #40;
    spi_bits(32'h81, 8, 0, rd);
    rst_n = 1'b0;
    #50;
    rst_n = 1'b1;
    #100;
    spi_bits(32'hAA, 8, 8, rd);
    #40;
    ncs_i = 1'b1;
    #200;
    check("rst_frame_regs", 64'(regs_now()), 64'h0);
    check("rst_frame_done", 64'(done_cnt - d0), 64'h0);

    d0 = done_cnt;
    spi_frame(32'h8103, 16, rd);
    check("after_rst_regs", 64'(regs_now()), 64'h00_03_00_00_00);
    check("after_rst_done", 64'(done_cnt - d0), 64'h1);

    // write duty 0x3C then read it back
    d0 = done_cnt;
    spi_frame(32'h843C, 16, rd);
    spi_frame(32'h0400, 16, rd);
`ifdef SPI_READBACK_EN
    check("readback_cipo", 64'(rd), 64'h3C);
`else
    check("readback_cipo", 64'(rd), 64'h00);
`endif
    check("readback_done", 64'(done_cnt - d0), 64'(1 + RD_DONE));
    check("readback_regs", 64'(regs_now()), 64'h00_03_00_00_3C);
    check("idle_cipo", 64'(cipo_o), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
